multi_delay_timer: RTL

//  Multi-channel microsecond delay timer, parametrised successor to the single-channel delay counter.
//  One shared prescaler generates a 1 us tick from CLK. NUM_CH independent channels each count a

---
 rtl/delay_timer_pkg.sv | 6 +
 rtl/delay_timer_channel.sv | 69 ++++++
 rtl/multi_delay_timer.sv | 52 +++++
 3 files changed

// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: channel state and mode encodings shared by the delay timer files
package delay_timer_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/delay_timer_channel.sv
// delay_timer_channel: one delay channel, counts latched delay in us ticks, one-shot or auto-reload
module delay_timer_channel
   import delay_timer_pkg::*;
#(
   parameter int DELAY_W = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               i_tick,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_periodic,
   input  logic [DELAY_W-1:0] i_delay,
   output logic               o_busy,
   output logic               o_done
);
   state_t             r_state, w_state;
   logic [DELAY_W-1:0] r_rem, w_rem, r_dly, w_dly;
   logic               r_per, w_per, r_done, w_done;

   // stop beats start, start beats tick
   always_comb begin
      w_state = r_state;
      w_rem   = r_rem;
      w_dly   = r_dly;
      w_per   = r_per;
      w_done  = 1'b0;
      if (i_stop) begin
         w_state = ST_IDLE;
      end else if (i_start) begin
         if (i_delay != '0) begin
            w_state = ST_RUN;
            w_rem   = i_delay;
            w_dly   = i_delay;
            w_per   = i_periodic;
         end else begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
         end
      end else if (r_state == ST_RUN && i_tick) begin
         if (r_rem > DELAY_W'(1)) begin
            w_rem = r_rem - DELAY_W'(1);
         end else begin
            w_done  = 1'b1;
            w_rem   = r_dly;
            w_state = (r_per == MODE_PERIODIC) ? ST_RUN : ST_IDLE;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_dly   <= '0;
         r_per   <= MODE_ONESHOT;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_rem   <= w_rem;
         r_dly   <= w_dly;
         r_per   <= w_per;
         r_done  <= w_done;
      end
   end

   assign o_busy = (r_state == ST_RUN);
   assign o_done = r_done;
endmodule

// File: rtl/multi_delay_timer.sv
// multi_delay_timer: shared 1 us prescaler driving NUM_CH independent delay channels
module multi_delay_timer
   import delay_timer_pkg::*;
#(
   parameter int CLOCK_SPEED_MHZ = 12,
   parameter int NUM_CH          = 4,
   parameter int DELAY_W         = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_CH-1:0]         start,
   input  logic [NUM_CH-1:0]         stop,
   input  logic [NUM_CH-1:0]         periodic,
   input  logic [NUM_CH*DELAY_W-1:0] delay_us,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done,
   output logic                      us_tick
);
   localparam int PW = (CLOCK_SPEED_MHZ > 1) ? $clog2(CLOCK_SPEED_MHZ) : 1;

   logic [PW-1:0] r_cnt;
   logic          r_tick;
   logic          w_wrap;

   assign w_wrap = (r_cnt == PW'(CLOCK_SPEED_MHZ - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_wrap ? '0 : r_cnt + PW'(1);
         r_tick <= w_wrap;
      end
   end

   assign us_tick = r_tick;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      delay_timer_channel #(.DELAY_W(DELAY_W)) u_ch (
         .CLK        (CLK),
         .RST        (RST),
         .i_tick     (r_tick),
         .i_start    (start[c]),
         .i_stop     (stop[c]),
         .i_periodic (periodic[c]),
         .i_delay    (delay_us[c*DELAY_W +: DELAY_W]),
         .o_busy     (busy[c]),
         .o_done     (done[c])
      );
   end
endmodule
